// File: rtl/id_hazard_ctrl_pkg.sv
// rtl/id_hazard_ctrl_pkg.sv - opcode, select encodings and state type for the ID hazard controller
//
// Purpose: shared constants for the ID-stage controller and its forwarding selector.
// Ports  : none (package).
package id_ctrl_pkg;

  // Opcodes (inst[31:26]) the controller decodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Branch operand select encodings
  localparam logic [1:0] FB_RF   = 2'b00;
  localparam logic [1:0] FB_WB   = 2'b01;
  localparam logic [1:0] FB_EX   = 2'b10;
  localparam logic [1:0] FB_ZERO = 2'b11;

  // Next-PC select encodings
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_ZERO   = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } ctrlState_t;

  // $zero is hardwired, so a write to it never creates a dependency
  function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] src);
    return (rd != 5'd0) && (rd == src);
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// rtl/id_hazard_ctrl_if.sv - ID-stage control bus between pipeline and hazard controller
//
// Purpose: bundles the decode/pipeline-status inputs and the control outputs.
// Ports  : master drives the pipeline-status side; slave (the controller) drives
//          forbranchA/B, PCsrc, pc_write, ifid_write, ifid_flush, idex_bubble, stall_count.
interface id_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             cmp_eq;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             mem_regwrite;
  logic             mem_memread;
  logic [4:0]       mem_rd;
  logic             wb_regwrite;
  logic [4:0]       wb_rd;
  logic [1:0]       forbranchA;
  logic [1:0]       forbranchB;
  logic [1:0]       PCsrc;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_opcode, id_rs, id_rt, cmp_eq,
    output ex_regwrite, ex_memread, ex_rd,
    output mem_regwrite, mem_memread, mem_rd,
    output wb_regwrite, wb_rd,
    input  forbranchA, forbranchB, PCsrc, pc_write, ifid_write,
    input  ifid_flush, idex_bubble, stall_count
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, cmp_eq,
    input  ex_regwrite, ex_memread, ex_rd,
    input  mem_regwrite, mem_memread, mem_rd,
    input  wb_regwrite, wb_rd,
    output forbranchA, forbranchB, PCsrc, pc_write, ifid_write,
    output ifid_flush, idex_bubble, stall_count
  );

endinterface

// File: rtl/id_hazard_ctrl_fwd_sel.sv
// rtl/id_hazard_ctrl_fwd_sel.sv - branch operand forwarding select for one source register
//
// Purpose: picks where the ID comparator gets one operand from.
// Ports  : src (operand register), memRegWrite/memMemRead/memRd (EX/MEM),
//          wbRegWrite/wbRd (MEM/WB), sel (FB_* encoding).
module id_fwd_sel
  import id_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       memRegWrite,
  input  logic       memMemRead,
  input  logic [4:0] memRd,
  input  logic       wbRegWrite,
  input  logic [4:0] wbRd,
  output logic [1:0] sel
);

  // A load in EX/MEM has no data yet, so it cannot forward; the hazard
  // logic stalls for that case instead.
  always_comb begin
    sel = FB_RF;
    if (memRegWrite && !memMemRead && regMatch(memRd, src)) begin
      sel = FB_EX;
    end else if (wbRegWrite && regMatch(wbRd, src)) begin
      sel = FB_WB;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage stall/flush/forwarding/next-PC controller
//
// Purpose: decides stalls, IF/ID flushes, branch operand forwarding and next-PC
//          select for the ID stage; counts stall cycles (saturating).
// Ports  : clk, rst (sync, active-high); bus (slave modport) carries the decode
//          and pipeline-status inputs and all control outputs.
module id_hazard_ctrl
  import id_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int BOOT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  id_hazard_ctrl_if.slave bus
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES - 1);

  ctrlState_t       state, stateNext;
  logic [BOOT_W-1:0] bootCnt, bootCntNext;
  logic             stallCnt, stallCntNext;
  logic [CNT_W-1:0] stallCount;
  logic             stallCycle;

  logic       isBr, usesRt, taken, isJump;
  logic       exMatch, memMatch, exMatchLoadUse;
  logic [1:0] hazN;
  logic [1:0] fwdA, fwdB;

  // Decode
  assign isJump = (bus.id_opcode == OP_J);
  assign isBr   = (bus.id_opcode == OP_BEQ) || (bus.id_opcode == OP_BNE);
  assign usesRt = (bus.id_opcode == OP_RTYPE) || (bus.id_opcode == OP_SW) || isBr;
  assign taken  = ((bus.id_opcode == OP_BEQ) &&  bus.cmp_eq) ||
                  ((bus.id_opcode == OP_BNE) && !bus.cmp_eq);

  // Branches read both rs and rt in ID, so "matches a source" means either.
  assign exMatch        = regMatch(bus.ex_rd, bus.id_rs) || regMatch(bus.ex_rd, bus.id_rt);
  assign memMatch       = regMatch(bus.mem_rd, bus.id_rs) || regMatch(bus.mem_rd, bus.id_rt);
  assign exMatchLoadUse = regMatch(bus.ex_rd, bus.id_rs) ||
                          (usesRt && regMatch(bus.ex_rd, bus.id_rt));

  // Number of stall cycles needed; a load feeding a branch must wait until
  // it leaves MEM, hence two.
  always_comb begin
    hazN = 2'd0;
    if (isBr && bus.ex_memread && exMatch) begin
      hazN = 2'd2;
    end else if (bus.ex_memread && exMatchLoadUse) begin
      hazN = 2'd1;
    end else if (isBr && bus.ex_regwrite && !bus.ex_memread && exMatch) begin
      hazN = 2'd1;
    end else if (isBr && bus.mem_memread && memMatch) begin
      hazN = 2'd1;
    end
  end

  id_fwd_sel u_fwdA (
    .src         (bus.id_rs),
    .memRegWrite (bus.mem_regwrite),
    .memMemRead  (bus.mem_memread),
    .memRd       (bus.mem_rd),
    .wbRegWrite  (bus.wb_regwrite),
    .wbRd        (bus.wb_rd),
    .sel         (fwdA)
  );

  id_fwd_sel u_fwdB (
    .src         (bus.id_rt),
    .memRegWrite (bus.mem_regwrite),
    .memMemRead  (bus.mem_memread),
    .memRd       (bus.mem_rd),
    .wbRegWrite  (bus.wb_regwrite),
    .wbRd        (bus.wb_rd),
    .sel         (fwdB)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BOOT;
      bootCnt    <= BOOT_INIT;
      stallCnt   <= 1'b0;
      stallCount <= '0;
    end else begin
      state    <= stateNext;
      bootCnt  <= bootCntNext;
      stallCnt <= stallCntNext;
      if (stallCycle && (stallCount != {CNT_W{1'b1}})) begin
        stallCount <= stallCount + 1'b1;
      end
    end
  end

  always_comb begin
    stateNext       = state;
    bootCntNext     = bootCnt;
    stallCntNext    = stallCnt;
    stallCycle      = 1'b0;
    bus.PCsrc       = PC_SEQ;
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.forbranchA  = fwdA;
    bus.forbranchB  = fwdB;

    case (state)
      ST_BOOT: begin
        bus.PCsrc       = PC_ZERO;
        bus.forbranchA  = FB_ZERO;
        bus.forbranchB  = FB_ZERO;
        bus.ifid_flush  = 1'b1;
        bus.idex_bubble = 1'b1;
        if (bootCnt == '0) begin
          stateNext = ST_RUN;
        end else begin
          bootCntNext = bootCnt - 1'b1;
        end
      end

      ST_STALL: begin
        // Hazard inputs are deliberately not looked at here.
        stallCycle      = 1'b1;
        bus.pc_write    = 1'b0;
        bus.ifid_write  = 1'b0;
        bus.idex_bubble = 1'b1;
        stallCntNext    = stallCnt - 1'b1;
        if (stallCnt == 1'b1) begin
          stateNext = ST_RUN;
        end
      end

      default: begin
        if (hazN != 2'd0) begin
          stallCycle      = 1'b1;
          bus.pc_write    = 1'b0;
          bus.ifid_write  = 1'b0;
          bus.idex_bubble = 1'b1;
          if (hazN == 2'd2) begin
            stateNext    = ST_STALL;
            stallCntNext = 1'b1;
          end
        end else if (isJump) begin
          bus.PCsrc      = PC_JUMP;
          bus.ifid_flush = 1'b1;
        end else if (isBr && taken) begin
          bus.PCsrc      = PC_BRANCH;
          bus.ifid_flush = 1'b1;
        end
      end
    endcase
  end

  assign bus.stall_count = stallCount;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - directed self-checking bench for id_hazard_ctrl
module tb_id_hazard_ctrl;
  import id_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nTotal = 0;
  int   nPass  = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  id_hazard_ctrl #(.CNT_W(CNT_W), .BOOT_CYCLES(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    bus.id_opcode    = OP_RTYPE;
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.cmp_eq       = 1'b0;
    bus.ex_regwrite  = 1'b0;
    bus.ex_memread   = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.mem_regwrite = 1'b0;
    bus.mem_memread  = 1'b0;
    bus.mem_rd       = 5'd0;
    bus.wb_regwrite  = 1'b0;
    bus.wb_rd        = 5'd0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("boot_pcsrc", 32'(bus.PCsrc), 32'h3);
    chk("boot_fbA", 32'(bus.forbranchA), 32'h3);
    chk("boot_fbB", 32'(bus.forbranchB), 32'h3);
    chk("boot_flush", 32'(bus.ifid_flush), 32'h1);
    chk("boot_bubble", 32'(bus.idex_bubble), 32'h1);
    chk("boot_count", 32'(bus.stall_count), 32'h0);

    tick(); #1;
    chk("run_pcsrc", 32'(bus.PCsrc), 32'h0);
    chk("run_pcwrite", 32'(bus.pc_write), 32'h1);
    chk("run_flush", 32'(bus.ifid_flush), 32'h0);
    chk("run_count", 32'(bus.stall_count), 32'h0);

    // load-use on rs
    bus.id_rs = 5'd5; bus.id_rt = 5'd6;
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd5;
    #1;
    chk("lu_pcwrite", 32'(bus.pc_write), 32'h0);
    chk("lu_ifidwrite", 32'(bus.ifid_write), 32'h0);
    chk("lu_bubble", 32'(bus.idex_bubble), 32'h1);
    tick();
    bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_rd = 5'd0;
    #1;
    chk("lu_release_pcwrite", 32'(bus.pc_write), 32'h1);
    chk("lu_release_bubble", 32'(bus.idex_bubble), 32'h0);
    chk("lu_count", 32'(bus.stall_count), 32'h1);

    // LW does not read rt; $zero never matches
    bus.id_opcode = OP_LW; bus.id_rs = 5'd1; bus.id_rt = 5'd5;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
    #1;
    chk("lw_rt_nohaz", 32'(bus.pc_write), 32'h1);
    bus.id_opcode = OP_RTYPE; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.ex_rd = 5'd0;
    #1;
    chk("r0_nohaz", 32'(bus.pc_write), 32'h1);

    // branch after load: two stall cycles
    clr();
    bus.id_opcode = OP_BEQ; bus.id_rs = 5'd2; bus.id_rt = 5'd7; bus.cmp_eq = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd7;
    #1;
    chk("br2_s1_pcwrite", 32'(bus.pc_write), 32'h0);
    chk("br2_s1_pcsrc", 32'(bus.PCsrc), 32'h0);
    chk("br2_s1_flush", 32'(bus.ifid_flush), 32'h0);
    tick();
    bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_rd = 5'd0;
    #1;
    chk("br2_s2_pcwrite", 32'(bus.pc_write), 32'h0);
    chk("br2_s2_pcsrc", 32'(bus.PCsrc), 32'h0);
    chk("br2_s2_bubble", 32'(bus.idex_bubble), 32'h1);
    chk("br2_s2_count", 32'(bus.stall_count), 32'h2);
    tick();
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd7;
    #1;
    chk("br2_fbB", 32'(bus.forbranchB), 32'h2);
    chk("br2_fbA", 32'(bus.forbranchA), 32'h0);
    chk("br2_pcsrc", 32'(bus.PCsrc), 32'h2);
    chk("br2_flush", 32'(bus.ifid_flush), 32'h1);
    chk("br2_pcwrite", 32'(bus.pc_write), 32'h1);
    chk("br2_count", 32'(bus.stall_count), 32'h3);

    // BNE forwarding priority
    clr();
    bus.id_opcode = OP_BNE; bus.id_rs = 5'd3; bus.id_rt = 5'd4; bus.cmp_eq = 1'b0;
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd3; bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd3;
    #1;
    chk("bne_fbA_ex", 32'(bus.forbranchA), 32'h2);
    chk("bne_pcsrc", 32'(bus.PCsrc), 32'h2);
    bus.mem_regwrite = 1'b0;
    #1;
    chk("bne_fbA_wb", 32'(bus.forbranchA), 32'h1);
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
    #1;
    chk("bne_fbA_rf", 32'(bus.forbranchA), 32'h0);
    bus.cmp_eq = 1'b1;
    #1;
    chk("bne_nt_pcsrc", 32'(bus.PCsrc), 32'h0);
    chk("bne_nt_flush", 32'(bus.ifid_flush), 32'h0);
    bus.mem_memread = 1'b1; bus.mem_rd = 5'd3;
    #1;
    chk("bne_memload_stall", 32'(bus.pc_write), 32'h0);
    chk("bne_memload_fbA", 32'(bus.forbranchA), 32'h0);
    tick();

    // branch on ALU result still in EX
    clr();
    bus.id_opcode = OP_BEQ; bus.id_rs = 5'd9; bus.id_rt = 5'd10;
    bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd9;
    #1;
    chk("br_alu_stall", 32'(bus.pc_write), 32'h0);
    tick();

    // jump behind load-use
    clr();
    bus.id_opcode = OP_J; bus.id_rs = 5'd8; bus.ex_memread = 1'b1; bus.ex_rd = 5'd8;
    #1;
    chk("j_stall", 32'(bus.pc_write), 32'h0);
    tick();
    bus.ex_memread = 1'b0;
    #1;
    chk("j_pcsrc", 32'(bus.PCsrc), 32'h1);
    chk("j_flush", 32'(bus.ifid_flush), 32'h1);
    chk("j_count", 32'(bus.stall_count), 32'h6);

    // reset in the middle of a two-cycle stall
    clr();
    bus.id_opcode = OP_BEQ; bus.id_rs = 5'd7; bus.ex_memread = 1'b1; bus.ex_rd = 5'd7;
    tick(); #1;
    chk("mid_stall_pcwrite", 32'(bus.pc_write), 32'h0);
    chk("mid_stall_count", 32'(bus.stall_count), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_boot_pcsrc", 32'(bus.PCsrc), 32'h3);
    chk("rst_boot_count", 32'(bus.stall_count), 32'h0);
    tick();
    clr();
    #1;
    chk("rst_run_pcwrite", 32'(bus.pc_write), 32'h1);
    chk("rst_run_pcsrc", 32'(bus.PCsrc), 32'h0);

    // saturation: 19 stall cycles with a 4-bit counter
    bus.id_rs = 5'd5; bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
    for (int i = 0; i < 15; i++) tick();
    #1;
    chk("sat_15", 32'(bus.stall_count), 32'hF);
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("sat_19", 32'(bus.stall_count), 32'hF);
    chk("sat_pcwrite", 32'(bus.pc_write), 32'h0);
    clr();
    #1;
    chk("sat_release", 32'(bus.pc_write), 32'h1);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Pipeline controller for the ID stage of the 5-stage MIPS core.
- Decides stalls, IF/ID flushes, branch-operand forwarding selects (forbranchA/forbranchB) and the next-PC select (PCsrc) that drive the ID datapath.
- Tracks multi-cycle load/branch stalls with a small state machine and counter.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 16, width of the stall performance counter
- BOOT_CYCLES, 1, cycles PCsrc is held at 2'b11 (zero vector) after reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- id_opcode  in  6  inst[31:26] of the instruction in ID
- id_rs  in  5  inst[25:21]
- id_rt  in  5  inst[20:16]
- cmp_eq  in  1  ID comparator result (rs operand == rt operand)
- ex_regwrite  in  1  EX-stage instruction writes a register
- ex_memread  in  1  EX-stage instruction is a load
- ex_rd  in  5  EX-stage destination register
- mem_regwrite  in  1  EX/MEM-stage writes a register
- mem_memread  in  1  EX/MEM-stage is a load
- mem_rd  in  5  EX/MEM destination register
- wb_regwrite  in  1  MEM/WB-stage writes a register
- wb_rd  in  5  MEM/WB destination register
- forbranchA  out  2  rs operand select: 00 regfile, 01 writeData, 10 exOut, 11 zero
- forbranchB  out  2  rt operand select, same encoding as forbranchA
- PCsrc  out  2  next-PC select: 00 sequential, 01 jump {6'b0, inst[25:0]}, 10 branch pc+imm, 11 zero vector
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID register loads a NOP
- idex_bubble  out  1  ID/EX register loads a NOP (control bits zeroed)
- stall_count  out  CNT_W  saturating count of stall cycles since reset

Behaviour:
- Decode uses package constants: OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101, OP_J 000010.
  - uses_rt = RTYPE | SW | BEQ | BNE.
  - is_br = BEQ | BNE.
  - taken = (BEQ & cmp_eq) | (BNE & ~cmp_eq).
- Register 0 never matches in any hazard or forwarding compare.
- States: BOOT, RUN, STALL.
- Reset: state = BOOT, boot counter = BOOT_CYCLES-1, stall_cnt = 0, stall_count = 0.
- BOOT outputs: PCsrc = 11, forbranchA = forbranchB = 11, pc_write = 1, ifid_write = 1, ifid_flush = 1, idex_bubble = 1.
  - BOOT exits to RUN when the boot counter reaches 0.
- Hazard need N, evaluated combinationally in RUN; first matching rule wins:
  - N = 2: is_br & ex_memread & ex_rd matches a source.
  - N = 1: ex_memread & ex_rd matches rs, or matches rt when uses_rt (load-use).
  - N = 1: is_br & ex_regwrite & ~ex_memread & ex_rd matches a source.
  - N = 1: is_br & mem_memread & mem_rd matches a source.
  - N = 0: otherwise.
- Stall cycle (RUN with N > 0, or STALL state):
  - Outputs: pc_write = 0, ifid_write = 0, idex_bubble = 1, PCsrc = 00, ifid_flush = 0.
  - No redirect is taken while stalled.
- RUN with N = 2: go to STALL with stall_cnt = 1. RUN with N = 1: stay in RUN; hazard is re-evaluated next cycle.
- STALL: decrement stall_cnt; at 0 return to RUN. Hazard inputs are ignored while in STALL.
- RUN with N = 0:
  - pc_write = 1, ifid_write = 1, idex_bubble = 0.
  - OP_J: PCsrc = 01, ifid_flush = 1.
  - is_br & taken: PCsrc = 10, ifid_flush = 1.
  - Otherwise: PCsrc = 00, ifid_flush = 0.
- Forwarding (RUN and STALL), per operand:
  - 10 if mem_regwrite & ~mem_memread & mem_rd == src.
  - else 01 if wb_regwrite & wb_rd == src.
  - else 00.
  - EX/MEM has priority over MEM/WB.
- stall_count increments by 1 each stall cycle; saturates at all-ones and never wraps.
- rst asserted mid-stall abandons the stall immediately: next cycle is BOOT and counters are cleared.
- All outputs are combinational from registered state plus current inputs. Zero-cycle latency for stall/redirect decisions.

Decomposition:
- Package id_ctrl_pkg: opcode constants; FB_RF/FB_WB/FB_EX/FB_ZERO and PC_SEQ/PC_JUMP/PC_BRANCH/PC_ZERO 2-bit encodings; state enum.
- One sub-module, id_fwd_sel: combinational forwarding select for one operand, instantiated twice (rs, rt).

Test Plan:
- Reset 1 cycle, release -> BOOT cycle: PCsrc = 11, forbranchA = forbranchB = 11, flush and bubble = 1. Then RUN: PCsrc = 00, pc_write = 1, stall_count = 0.
- id_opcode = 100011? no: RTYPE with id_rs = 5, ex_memread = 1, ex_rd = 5 -> exactly 1 stall cycle (pc_write = 0, idex_bubble = 1, stall_count = 1). Next cycle with ex_memread = 0: pc_write = 1.
- BEQ with id_rt = 7, ex_memread = 1, ex_rd = 7 -> 2 stall cycles via STALL state, stall_count = 2, no PCsrc = 10 during stalls. Then mem_regwrite = 1, mem_rd = 7, cmp_eq = 1 -> forbranchB = 10, PCsrc = 10, ifid_flush = 1.
- BNE with rs = 3, mem_regwrite = 1, mem_rd = 3, wb_regwrite = 1, wb_rd = 3, cmp_eq = 0 -> forbranchA = 10 (priority), PCsrc = 10. Same with wb only -> forbranchA = 01. With rd = 0 -> forbranchA = 00.
- OP_J with ex_memread = 1, ex_rd = id_rs -> 1 stall, then PCsrc = 01, ifid_flush = 1. rst asserted during a 2-cycle branch stall -> next cycle BOOT, stall_count = 0.
- Force 2^CNT_W+3 stall cycles (CNT_W = 4 build) -> stall_count holds at 15, no wrap.
